// File: rtl/apb4_master_fsm.sv
// apb4_master_fsm
//   Pops packed commands {write, addr, byte_en, data} from the bridge command
//   FIFO and runs each as one APB4 transfer (SETUP then ACCESS). Every finished
//   transfer produces a one-cycle response pulse carrying read data and error.
//   This block is the only driver of the bridge's APB4 master signals.
//
// Ports
//   clk, reset          clock (posedge) and asynchronous active-high reset
//   fifo_empty          command FIFO empty flag
//   fifo_dout           FIFO read data, valid the cycle after fifo_rd_en
//   fifo_rd_en          pop request (combinational, never while empty)
//   PADDR/PWRITE/PWDATA/PSTRB  captured command, held until the next load
//   PSEL/PENABLE/PPROT  APB phase signals; PPROT = PPROT_VAL during a transfer
//   PREADY/PRDATA/PSLVERR      slave response
//   rsp_valid           one-cycle completion pulse
//   rsp_rdata/rsp_err   response payload, held until the next rsp_valid
//   busy                high in any state other than idle
//
// Optional feature
//   APB_TIMEOUT_EN: abort ACCESS as an error completion after TIMEOUT_CYCLES
//   not-ready wait cycles. Without it ACCESS waits for PREADY indefinitely.

module apb4_master_fsm #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ENTRY_W        = 1 + ADDR_W + DATA_W + DATA_W / 8,
  parameter logic [2:0]  PPROT_VAL      = 3'b000,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  fifo_empty,
  input  logic [ENTRY_W-1:0]    fifo_dout,
  output logic                  fifo_rd_en,
  output logic [ADDR_W-1:0]     PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_W-1:0]     PWDATA,
  output logic [DATA_W/8-1:0]   PSTRB,
  output logic [2:0]            PPROT,
  input  logic                  PREADY,
  input  logic [DATA_W-1:0]     PRDATA,
  input  logic                  PSLVERR,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_err,
  output logic                  busy
);

  localparam int unsigned StrbW = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StLoad, StSetup, StAccess} state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] paddr_q;
  logic              pwrite_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [StrbW-1:0]  pstrb_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic              rd_req;
  logic              load_en;
  logic              done;
  logic              done_err;
  logic [DATA_W-1:0] done_rdata;

  // Entry fields, MSB to LSB: write, addr, byte_en, data.
  logic              entry_write;
  logic [ADDR_W-1:0] entry_addr;
  logic [StrbW-1:0]  entry_strb;
  logic [DATA_W-1:0] entry_data;

  assign entry_write = fifo_dout[ENTRY_W-1];
  assign entry_addr  = fifo_dout[ENTRY_W-2 -: ADDR_W];
  assign entry_strb  = fifo_dout[DATA_W +: StrbW];
  assign entry_data  = fifo_dout[DATA_W-1:0];

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  always_comb begin
    state_d    = state_q;
    rd_req     = 1'b0;
    load_en    = 1'b0;
    PSEL       = 1'b0;
    PENABLE    = 1'b0;
    PPROT      = 3'b000;
    done       = 1'b0;
    done_err   = 1'b0;
    done_rdata = '0;
`ifdef APB_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          rd_req  = 1'b1;
          state_d = StLoad;
        end
      end
      StLoad: begin
        load_en = 1'b1;
        state_d = StSetup;
      end
      StSetup: begin
        PSEL    = 1'b1;
        PPROT   = PPROT_VAL;
        state_d = StAccess;
`ifdef APB_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      StAccess: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        PPROT   = PPROT_VAL;
        if (PREADY) begin
          done       = 1'b1;
          done_err   = PSLVERR;
          done_rdata = pwrite_q ? '0 : PRDATA;
`ifdef APB_TIMEOUT_EN
        end else if (cnt_q == CntW'(TIMEOUT_CYCLES)) begin
          done     = 1'b1;
          done_err = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
`endif
        end
        // Chain straight into the next entry so no idle cycle is spent.
        if (done) begin
          if (!fifo_empty) begin
            rd_req  = 1'b1;
            state_d = StLoad;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rsp_valid_q <= done;
      if (load_en) begin
        paddr_q  <= entry_addr;
        pwrite_q <= entry_write;
        pwdata_q <= entry_data;
        pstrb_q  <= entry_write ? entry_strb : '0;
      end
      if (done) begin
        rsp_rdata_q <= done_rdata;
        rsp_err_q   <= done_err;
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // Gated by reset so the pop request is low while reset is held.
  assign fifo_rd_en = rd_req & ~reset;
  assign PADDR      = paddr_q;
  assign PWRITE     = pwrite_q;
  assign PWDATA     = pwdata_q;
  assign PSTRB      = pstrb_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_rdata  = rsp_rdata_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != StIdle);

endmodule
